// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        FS_REQ,
        FS_WAIT,
        FS_HOLD
    } fetch_state_t;

    localparam logic [31:0] PC_STEP      = 32'd4;
    localparam logic [31:0] BUBBLE_INSTR = 32'h0;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter with async reset, load enable and next-PC mux.
module fetch_pc_reg
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        redirect,
    input  logic [31:0] target,
    output logic [31:0] pc_q
);

    logic [31:0] pc_d;

    // Redirect targets are forced word-aligned.
    always_comb begin
        pc_d = pc_q;
        if (load) begin
            pc_d = redirect ? (target & ~32'd3) : (pc_q + PC_STEP);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, issues one imem request at a time,
// holds the fetched word while decode stalls, applies redirects.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallf,
    input  logic        pcsrce,
    input  logic [31:0] pctargete,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instrf,
    output logic [31:0] pcf,
    output logic [31:0] pc_4f,
    output logic        fvalid
);

    fetch_state_t state_q, state_d;
    logic         kill_q, kill_d;
    logic [31:0]  ibuf_q, ibuf_d;
    logic         pc_load, pc_redir;
    logic [31:0]  pc_q;

    fetch_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk      (clk),
        .rst      (rst),
        .load     (pc_load),
        .redirect (pc_redir),
        .target   (pctargete),
        .pc_q     (pc_q)
    );

    assign imem_addr = pc_q;
    assign pcf       = pc_q;
    assign pc_4f     = pc_q + PC_STEP;

    always_comb begin
        state_d  = state_q;
        kill_d   = kill_q;
        ibuf_d   = ibuf_q;
        pc_load  = 1'b0;
        pc_redir = 1'b0;
        imem_req = 1'b0;
        fvalid   = 1'b0;
        instrf   = BUBBLE_INSTR;
        unique case (state_q)
            FS_REQ: begin
                imem_req = !pcsrce && !rst;
                if (pcsrce) begin
                    pc_load  = 1'b1;
                    pc_redir = 1'b1;
                end else begin
                    state_d = FS_WAIT;
                end
            end
            FS_WAIT: begin
                if (pcsrce) begin
                    pc_load  = 1'b1;
                    pc_redir = 1'b1;
                    if (imem_rvalid) begin
                        kill_d  = 1'b0;
                        state_d = FS_REQ;
                    end else begin
                        kill_d = 1'b1;
                    end
                end else if (imem_rvalid) begin
                    if (kill_q) begin
                        kill_d  = 1'b0;
                        state_d = FS_REQ;
                    end else begin
                        fvalid = 1'b1;
                        instrf = imem_rdata;
                        if (stallf) begin
                            ibuf_d  = imem_rdata;
                            state_d = FS_HOLD;
                        end else begin
                            pc_load = 1'b1;
                            state_d = FS_REQ;
                        end
                    end
                end
            end
            FS_HOLD: begin
                fvalid = !pcsrce;
                instrf = pcsrce ? BUBBLE_INSTR : ibuf_q;
                if (pcsrce) begin
                    pc_load  = 1'b1;
                    pc_redir = 1'b1;
                    state_d  = FS_REQ;
                end else if (!stallf) begin
                    pc_load = 1'b1;
                    state_d = FS_REQ;
                end
            end
            default: begin
                state_d = FS_REQ;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FS_REQ;
            kill_q  <= 1'b0;
            ibuf_q  <= BUBBLE_INSTR;
        end else begin
            state_q <= state_d;
            kill_q  <= kill_d;
            ibuf_q  <= ibuf_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a variable-latency imem model.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        stallf;
    logic        pcsrce;
    logic [31:0] pctargete;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] instrf;
    logic [31:0] pcf;
    logic [31:0] pc_4f;
    logic        fvalid;

    logic        req2;
    logic [31:0] addr2;
    logic        rv2;
    logic [31:0] instr2;
    logic [31:0] pcf2;
    logic [31:0] pc4_2;
    logic        fv2;

    int          vectors;
    int          miscompares;

    // memory model state
    int          lat;
    logic        pend;
    int          cnt;
    logic [31:0] paddr;
    logic        stray;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .rst         (rst),
        .stallf      (stallf),
        .pcsrce      (pcsrce),
        .pctargete   (pctargete),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instrf      (instrf),
        .pcf         (pcf),
        .pc_4f       (pc_4f),
        .fvalid      (fvalid)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
        .clk         (clk),
        .rst         (rst),
        .stallf      (1'b0),
        .pcsrce      (1'b0),
        .pctargete   (32'h0),
        .imem_req    (req2),
        .imem_addr   (addr2),
        .imem_rvalid (rv2),
        .imem_rdata  (32'h0000_0013),
        .instrf      (instr2),
        .pcf         (pcf2),
        .pc_4f       (pc4_2),
        .fvalid      (fv2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mw(input logic [31:0] a);
        case (a)
            32'h0:   mw = 32'h0050_0093;
            32'h4:   mw = 32'h0010_0113;
            default: mw = a ^ 32'h5A5A_0013;
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pend  <= 1'b0;
            cnt   <= 0;
            paddr <= 32'h0;
        end else if (imem_req) begin
            pend  <= 1'b1;
            cnt   <= lat - 1;
            paddr <= imem_addr;
        end else if (pend) begin
            if (cnt == 0) pend <= 1'b0;
            else cnt <= cnt - 1;
        end
    end

    assign imem_rvalid = (pend && cnt == 0) || stray;
    assign imem_rdata  = mw(paddr);

    always @(posedge clk or posedge rst) begin
        if (rst) rv2 <= 1'b0;
        else rv2 <= req2;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        stallf      = 1'b0;
        pcsrce      = 1'b0;
        pctargete   = 32'h0;
        lat         = 1;
        stray       = 1'b0;

        // reset state
        @(negedge clk);
        chk("rst_req", {31'b0, imem_req}, 32'd0);
        chk("rst_fvalid", {31'b0, fvalid}, 32'd0);
        chk("rst_instrf", instrf, 32'h0);
        chk("rst_pcf", pcf, 32'h0);
        chk("rst_pc4", pc_4f, 32'h4);
        chk("rst2_pcf", pcf2, 32'hFFFF_FFFC);
        chk("rst2_pc4", pc4_2, 32'h0);
        next_cycle();
        rst = 1'b0;

        // A: request to 0x0
        @(negedge clk);
        chk("a_req", {31'b0, imem_req}, 32'd1);
        chk("a_addr", imem_addr, 32'h0);
        chk("a_fvalid", {31'b0, fvalid}, 32'd0);
        chk("a2_req", {31'b0, req2}, 32'd1);
        chk("a2_addr", addr2, 32'hFFFF_FFFC);
        next_cycle();

        // B: response for 0x0
        @(negedge clk);
        chk("b_fvalid", {31'b0, fvalid}, 32'd1);
        chk("b_instr", instrf, 32'h0050_0093);
        chk("b_pcf", pcf, 32'h0);
        chk("b_pc4", pc_4f, 32'h4);
        chk("b_req", {31'b0, imem_req}, 32'd0);
        chk("b2_fvalid", {31'b0, fv2}, 32'd1);
        chk("b2_pcf", pcf2, 32'hFFFF_FFFC);
        chk("b2_pc4", pc4_2, 32'h0);
        next_cycle();

        // C: request to 0x4
        @(negedge clk);
        chk("c_req", {31'b0, imem_req}, 32'd1);
        chk("c_addr", imem_addr, 32'h4);
        chk("c_fvalid", {31'b0, fvalid}, 32'd0);
        chk("c2_addr", addr2, 32'h0);
        chk("c2_req", {31'b0, req2}, 32'd1);
        next_cycle();

        // D: response for 0x4
        @(negedge clk);
        chk("d_fvalid", {31'b0, fvalid}, 32'd1);
        chk("d_instr", instrf, 32'h0010_0113);
        chk("d_pcf", pcf, 32'h4);
        chk("d_pc4", pc_4f, 32'h8);
        next_cycle();

        // E: request to 0x8
        @(negedge clk);
        chk("e_addr", imem_addr, 32'h8);
        next_cycle();

        // F,G,H: stalled with word for 0x8
        stallf = 1'b1;
        @(negedge clk);
        chk("f_fvalid", {31'b0, fvalid}, 32'd1);
        chk("f_instr", instrf, 32'h5A5A_001B);
        chk("f_pcf", pcf, 32'h8);
        next_cycle();
        @(negedge clk);
        chk("g_fvalid", {31'b0, fvalid}, 32'd1);
        chk("g_instr", instrf, 32'h5A5A_001B);
        chk("g_req", {31'b0, imem_req}, 32'd0);
        chk("g_pcf", pcf, 32'h8);
        next_cycle();
        @(negedge clk);
        chk("h_instr", instrf, 32'h5A5A_001B);
        chk("h_req", {31'b0, imem_req}, 32'd0);
        next_cycle();

        // I: release, still presenting held word
        stallf = 1'b0;
        @(negedge clk);
        chk("i_fvalid", {31'b0, fvalid}, 32'd1);
        chk("i_instr", instrf, 32'h5A5A_001B);
        next_cycle();

        // J: request to 0xC
        @(negedge clk);
        chk("j_req", {31'b0, imem_req}, 32'd1);
        chk("j_addr", imem_addr, 32'hC);
        next_cycle();

        // K: response for 0xC; switch to 3-cycle memory
        lat = 3;
        @(negedge clk);
        chk("k_pcf", pcf, 32'hC);
        chk("k_instr", instrf, 32'h5A5A_001F);
        next_cycle();

        // L: request to 0x10
        @(negedge clk);
        chk("l_addr", imem_addr, 32'h10);
        next_cycle();

        // M: redirect to 0x100 while waiting
        pcsrce    = 1'b1;
        pctargete = 32'h100;
        @(negedge clk);
        chk("m_fvalid", {31'b0, fvalid}, 32'd0);
        chk("m_req", {31'b0, imem_req}, 32'd0);
        next_cycle();
        pcsrce = 1'b0;

        // N: still waiting for killed response
        @(negedge clk);
        chk("n_req", {31'b0, imem_req}, 32'd0);
        chk("n_pcf", pcf, 32'h100);
        next_cycle();

        // O: killed response arrives
        @(negedge clk);
        chk("o_rvalid", {31'b0, imem_rvalid}, 32'd1);
        chk("o_fvalid", {31'b0, fvalid}, 32'd0);
        chk("o_instr", instrf, 32'h0);
        next_cycle();

        // P: request to 0x100
        @(negedge clk);
        chk("p_req", {31'b0, imem_req}, 32'd1);
        chk("p_addr", imem_addr, 32'h100);
        next_cycle();
        next_cycle();
        next_cycle();

        // S: response with simultaneous redirect to 0x203 and stall
        pcsrce    = 1'b1;
        pctargete = 32'h203;
        stallf    = 1'b1;
        @(negedge clk);
        chk("s_rvalid", {31'b0, imem_rvalid}, 32'd1);
        chk("s_fvalid", {31'b0, fvalid}, 32'd0);
        chk("s_instr", instrf, 32'h0);
        next_cycle();
        pcsrce = 1'b0;

        // T: request to 0x200 despite stall
        @(negedge clk);
        chk("t_req", {31'b0, imem_req}, 32'd1);
        chk("t_addr", imem_addr, 32'h200);
        next_cycle();

        // U: reset mid-WAIT
        rst    = 1'b1;
        stallf = 1'b0;
        lat    = 1;
        @(negedge clk);
        chk("u_req", {31'b0, imem_req}, 32'd0);
        chk("u_pcf", pcf, 32'h0);
        chk("u_fvalid", {31'b0, fvalid}, 32'd0);
        next_cycle();
        rst   = 1'b0;
        stray = 1'b1;

        // V: request to RESET_PC with stray rvalid
        @(negedge clk);
        chk("v_req", {31'b0, imem_req}, 32'd1);
        chk("v_addr", imem_addr, 32'h0);
        chk("v_fvalid", {31'b0, fvalid}, 32'd0);
        chk("v_instr", instrf, 32'h0);
        next_cycle();
        stray = 1'b0;

        // W: genuine response after reset
        @(negedge clk);
        chk("w_fvalid", {31'b0, fvalid}, 32'd1);
        chk("w_instr", instrf, 32'h0050_0093);
        chk("w_pcf", pcf, 32'h0);
        next_cycle();

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the five-stage RISC-V pipeline. Owns the program counter, issues one instruction-memory request at a time over a variable-latency request/response interface, and holds the fetched word while decode is stalled. It also applies taken-branch/jump redirects from execute. Outputs `instrf`, `pcf`, `pc_4f` feed the fetch/decode pipeline register directly; `fvalid`=0 marks a bubble, and then `instrf`=0, which matches the value that register loads on flush.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.
- `clk`  in  1  pipeline clock; all state updates on posedge.
- `rst`  in  1  asynchronous, active-high reset.
- `stallf`  in  1  hazard unit: hold the current fetch; do not advance PC.
- `pcsrce`  in  1  execute: redirect to `pctargete` (taken branch / jal / jalr).
- `pctargete`  in  32  redirect target; bits [1:0] ignored (treated as 0).
- `imem_req`  out  1  request strobe; one-cycle pulse per fetch.
- `imem_addr`  out  32  request address, equal to `pcf`.
- `imem_rvalid`  in  1  response valid; at most one per request, ≥1 cycle after request.
- `imem_rdata`  in  32  response instruction word.
- `instrf`  out  32  instruction to decode; 0 when `fvalid`=0.
- `pcf`  out  32  PC of `instrf`.
- `pc_4f`  out  32  `pcf`+4, modulo 2^32.
- `fvalid`  out  1  `instrf` is a valid, consumable instruction this cycle.

## Operation
- Registers: `pc` (32b), `state` in {REQ, WAIT, HOLD}, `ibuf` (32b).
- Reset values: `pc`=RESET_PC, `state`=REQ, `ibuf`=0. During reset, `imem_req`=0, `fvalid`=0, `instrf`=0, `pcf`=RESET_PC, `pc_4f`=RESET_PC+4.
- REQ
  - `imem_req` = !pcsrce, with `imem_addr`=pc.
  - If `pcsrce`: `pc`<=target and stay in REQ. No request is issued.
  - Otherwise: go to WAIT. `stallf` does not block issuing.
- WAIT
  - If `imem_rvalid` && !pcsrce: present `imem_rdata` combinationally, with `fvalid`=1.
    - If !stallf: `pc`<=pc+4, go to REQ.
    - If stallf: `ibuf`<=imem_rdata, go to HOLD.
  - If `pcsrce`: `pc`<=target.
    - If `imem_rvalid` is high the same cycle: drop the response and go to REQ.
    - Otherwise: set `kill`, stay in WAIT. The next response is dropped, then `kill` clears and the FSM goes to REQ.
  - `fvalid`=0 while waiting, and for any killed response.
- HOLD
  - Present `ibuf`, with `fvalid`=!pcsrce.
  - If `pcsrce`: `pc`<=target, go to REQ.
  - Else if !stallf: `pc`<=pc+4, go to REQ.
  - Else stay in HOLD.
- Priority: `pcsrce` beats `stallf` in every state.
- `imem_rvalid` outside WAIT is ignored.
- `kill` is a 1-bit register, reset 0.
- Arithmetic is 32-bit and wraps: 0xFFFF_FFFC+4 = 0. Redirect writes {pctargete[31:2],2'b00}.

## Timing
- Best-case throughput is 1 instruction per 2 cycles, with 1-cycle memory (REQ→WAIT).
- Latency from request to `fvalid` equals the memory latency (≥1 cycle).
- `instrf`/`fvalid` are combinational from `imem_rdata`/`imem_rvalid` in WAIT, and registered in HOLD.
- A redirect takes effect at the next edge. The first request to the target is issued in the cycle after `pcsrce`, or later if a killed response is still pending.
- Asynchronous reset mid-WAIT or mid-HOLD abandons the transaction immediately and returns the FSM to REQ. The memory is reset from the same `rst`.

## Structure
- Shared package `fetch_pkg`:
  - state enum `fetch_state_t` {FS_REQ, FS_WAIT, FS_HOLD}
  - `PC_STEP`=4
  - `BUBBLE_INSTR`=32'h0
- Sub-module `fetch_pc_reg`: 32-bit PC register with async reset to RESET_PC, load-enable, and next-PC mux (pc+4 / redirect).
- The FSM, `kill` flag, and `ibuf` live in `fetch_unit`.

## Test plan
- Reset release with 1-cycle memory returning 0x00500093, 0x00100113 → `imem_req` pulses at 0x0 then 0x4. `fvalid` is high every other cycle with `pcf`=0x0, then 0x4. `pc_4f`=0x4, then 0x8.
- `stallf`=1 for 3 cycles when the word for 0x8 arrives → HOLD. `instrf` stays constant with `pcf`=0x8 and no new `imem_req`. After release, the next request is to 0xC.
- 3-cycle memory, `pcsrce`=1 with target 0x100 one cycle after the request to 0x10 → the 0x10 response is dropped with `fvalid`=0. The next `imem_req` is to 0x100.
- `pcsrce`=1 with target 0x203 in the same cycle as `imem_rvalid`, with `stallf`=1 → no `fvalid`. The next request is to 0x200, so redirect beats stall.
- `RESET_PC`=0xFFFF_FFFC → first fetch at 0xFFFF_FFFC with `pc_4f`=0. The next request is to 0x0.
- Assert `rst` while in WAIT, then release → `imem_req` to RESET_PC. A stray `imem_rvalid` in REQ produces no `fvalid`.
